// File: rtl/memarb_pkg.sv
// Shared types and default widths for the RAM port arbiter.
package memarb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;
  typedef enum logic {SRC_IF = 1'b0, SRC_D = 1'b1} src_t;

  localparam logic RAM_RD = 1'b0;
  localparam logic RAM_WR = 1'b1;

  localparam int DEF_ADDR_W     = 16;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_RAM_LAT    = 0;
  localparam int DEF_STARVE_MAX = 4;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and RAM side signals of the arbiter; slave = arbiter, master = requesters/RAM.
interface mem_port_arbiter_if
  import memarb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              ram_rw;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output ram_rw, ram_addr, ram_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  ram_rw, ram_addr, ram_wdata
  );
endinterface

// File: rtl/memarb_prio.sv
// Data-first grant decision with a saturating starvation counter that forces a fetch win.
module memarb_prio
  import memarb_pkg::*;
#(
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic clk,
  input  logic reset,
  input  logic idle,
  input  logic if_req,
  input  logic d_req,
  output logic if_gnt,
  output logic d_gnt
);
  logic [3:0] starve_cnt;
  logic       starved;

  assign starved = (starve_cnt == 4'(STARVE_MAX));

  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (idle && !reset) begin
      if (d_req && !(if_req && starved)) d_gnt = 1'b1;
      else if (if_req)                   if_gnt = 1'b1;
    end
  end

  // Only contended data wins count toward starving the fetch side.
  always_ff @(posedge clk) begin
    if (reset)                             starve_cnt <= '0;
    else if (if_gnt)                       starve_cnt <= '0;
    else if (d_gnt && if_req && !starved)  starve_cnt <= starve_cnt + 4'd1;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Registered request/grant/response controller for one shared RAM port (fetch vs data).
// Optional MEMARB_STALL_CNT_EN adds a saturating stall_cycles counter output.
module mem_port_arbiter
  import memarb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int RAM_LAT    = DEF_RAM_LAT,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic                     clk,
  input  logic                     reset,
  mem_port_arbiter_if.slave        bus,
  output logic                     busy
`ifdef MEMARB_STALL_CNT_EN
  ,
  output logic [15:0]              stall_cycles
`endif
);
  state_t            state, state_nxt;
  src_t              src;
  logic [2:0]        cnt;
  logic              if_gnt, d_gnt, take;
  logic              ram_rw_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q, if_rdata_q, d_rdata_q;

  memarb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .clk    (clk),
    .reset  (reset),
    .idle   (state == IDLE),
    .if_req (bus.if_req),
    .d_req  (bus.d_req),
    .if_gnt (if_gnt),
    .d_gnt  (d_gnt)
  );

  assign take = if_gnt | d_gnt;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = ACCESS;
      ACCESS:  if (cnt == 3'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src         <= SRC_IF;
      cnt         <= '0;
      ram_rw_q    <= RAM_RD;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            src        <= d_gnt ? SRC_D : SRC_IF;
            cnt        <= 3'(RAM_LAT);
            ram_addr_q <= d_gnt ? bus.d_addr : bus.if_addr;
            ram_rw_q   <= d_gnt ? bus.d_we : RAM_RD;
            if (d_gnt) ram_wdata_q <= bus.d_wdata;
          end
        end
        ACCESS: begin
          // Read data is valid in the last access cycle; stores return zero.
          if (cnt == 3'd0) begin
            ram_rw_q <= RAM_RD;
            if (src == SRC_D) d_rdata_q  <= (ram_rw_q == RAM_WR) ? '0 : bus.ram_rdata;
            else              if_rdata_q <= bus.ram_rdata;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.if_rvalid = (state == RESP) && (src == SRC_IF);
  assign bus.d_rvalid  = (state == RESP) && (src == SRC_D);
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.ram_rw    = ram_rw_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign busy          = (state != IDLE);

`ifdef MEMARB_STALL_CNT_EN
  logic stalled;
  assign stalled = (bus.if_req & ~if_gnt) | (bus.d_req & ~d_gnt);

  always_ff @(posedge clk) begin
    if (reset)                                  stall_cycles <= '0;
    else if (stalled && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
  end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and random stimulus against a cycle-timeline reference model of the arbiter.
module tb_mem_port_arbiter;
  localparam int AW = 16, DW = 32, LAT = 2, SMAX = 4;

  logic clk = 1'b0;
  logic reset;
  logic busy;
`ifdef MEMARB_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RAM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .busy         (busy)
`ifdef MEMARB_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  // Behavioural RAM with LAT-cycle read pipe, plus bench-side init/poke paths.
  logic [DW-1:0] ram_mem [0:1023];
  logic [DW-1:0] rd_pipe [0:7];
  logic          init_go, poke_en;
  logic [9:0]    poke_a;
  logic [DW-1:0] poke_d;

  always @(posedge clk) begin
    if (init_go) for (int k = 0; k < 1024; k++) ram_mem[k] <= 32'(k) * 32'h9E3779B1;
    else if (poke_en) ram_mem[poke_a] <= poke_d;
    else if (bus.ram_rw) ram_mem[bus.ram_addr[9:0]] <= bus.ram_wdata;
    rd_pipe[0] <= ram_mem[bus.ram_addr[9:0]];
    for (int k = 1; k < 8; k++) rd_pipe[k] <= rd_pipe[k-1];
  end

  if (LAT == 0) begin : g_l0
    assign bus.ram_rdata = ram_mem[bus.ram_addr[9:0]];
  end else begin : g_lp
    assign bus.ram_rdata = rd_pipe[LAT-1];
  end

  int checks = 0, errors = 0;

  // Reference model: transaction timeline expressed as cycle numbers.
  logic [DW-1:0] mmem [0:1024-1];
  int            cyc = 0, cur = 0, free_at = 0, due = -1, rw_from = 0, rw_to = -1, starve = 0;
  logic          due_d;
  logic [DW-1:0] due_data, m_wdata, m_if_rdata, m_d_rdata;
  logic [AW-1:0] m_addr;
  logic [15:0]   m_stall;
  logic          e_if_gnt, e_d_gnt, e_if_rv, e_d_rv;
  logic          o_if_gnt, o_d_gnt, o_if_rv, o_d_rv, o_rw, o_busy;
  logic [AW-1:0] o_ram_addr;
  logic [DW-1:0] o_if_rdata, o_d_rdata;
  logic [15:0]   o_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cur);
    end
  endtask

  task automatic step();
    logic idle;
    @(negedge clk);
    cur = cyc;
    o_if_gnt = bus.if_gnt;  o_d_gnt = bus.d_gnt;  o_if_rv = bus.if_rvalid; o_d_rv = bus.d_rvalid;
    o_rw = bus.ram_rw;      o_busy = busy;        o_ram_addr = bus.ram_addr;
    o_if_rdata = bus.if_rdata; o_d_rdata = bus.d_rdata;
    o_stall = '0;
`ifdef MEMARB_STALL_CNT_EN
    o_stall = stall_cycles;
`endif
    e_if_rv = 1'b0; e_d_rv = 1'b0;
    if (due == cyc) begin
      if (due_d) begin m_d_rdata = due_data; e_d_rv = 1'b1; end
      else begin m_if_rdata = due_data; e_if_rv = 1'b1; end
    end
    idle = (cyc >= free_at);
    e_d_gnt  = idle && !reset && bus.d_req && !(bus.if_req && starve == SMAX);
    e_if_gnt = idle && !reset && bus.if_req && !e_d_gnt;

    chk("if_gnt",    32'(o_if_gnt), 32'(e_if_gnt));
    chk("d_gnt",     32'(o_d_gnt),  32'(e_d_gnt));
    chk("if_rvalid", 32'(o_if_rv),  32'(e_if_rv));
    chk("d_rvalid",  32'(o_d_rv),   32'(e_d_rv));
    chk("if_rdata",  o_if_rdata,    m_if_rdata);
    chk("d_rdata",   o_d_rdata,     m_d_rdata);
    chk("ram_rw",    32'(o_rw),     32'(cyc >= rw_from && cyc <= rw_to));
    chk("ram_addr",  32'(o_ram_addr), 32'(m_addr));
    chk("ram_wdata", bus.ram_wdata, m_wdata);
    chk("busy",      32'(o_busy),   32'(cyc < free_at));
`ifdef MEMARB_STALL_CNT_EN
    chk("stall_cycles", 32'(o_stall), 32'(m_stall));
`endif

    if (reset) begin
      m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_d_rdata = '0; m_stall = '0;
      free_at = cyc + 1; due = -1; rw_to = -1; starve = 0;
    end else begin
      if (((bus.if_req && !e_if_gnt) || (bus.d_req && !e_d_gnt)) && m_stall != 16'hFFFF)
        m_stall = m_stall + 16'd1;
      if (e_d_gnt || e_if_gnt) begin
        free_at = cyc + LAT + 3;
        due     = cyc + LAT + 2;
        due_d   = e_d_gnt;
        m_addr  = e_d_gnt ? bus.d_addr : bus.if_addr;
        if (e_d_gnt) begin
          m_wdata = bus.d_wdata;
          if (bus.d_we) begin
            mmem[bus.d_addr[9:0]] = bus.d_wdata;
            due_data = '0; rw_from = cyc + 1; rw_to = cyc + LAT + 1;
          end else due_data = mmem[bus.d_addr[9:0]];
          if (bus.if_req) starve = (starve < SMAX) ? starve + 1 : SMAX;
        end else begin
          due_data = mmem[bus.if_addr[9:0]];
          starve   = 0;
        end
      end
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  int rw_seen, at;
  task automatic run_until_rv();
    at = -1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (o_rw) rw_seen++;
      if (o_if_rv || o_d_rv) begin at = cur; break; end
    end
    if (at < 0) chk("rvalid_timeout", 32'd0, 32'd1);
  endtask

  task automatic poke(input logic [9:0] a, input logic [DW-1:0] d);
    poke_en = 1'b1; poke_a = a; poke_d = d; mmem[a] = d;
    step();
    poke_en = 1'b0;
  endtask

  int t0, n, gcyc;
  logic [9:0] order;
  logic [15:0] s0;

  initial begin
    reset = 1'b1; init_go = 1'b1; poke_en = 1'b0; poke_a = '0; poke_d = '0;
    bus.if_req = 1'b0; bus.if_addr = '0; bus.d_req = 1'b0; bus.d_we = 1'b0;
    bus.d_addr = '0; bus.d_wdata = '0;
    for (int k = 0; k < 1024; k++) mmem[k] = 32'(k) * 32'h9E3779B1;
    m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_d_rdata = '0; m_stall = '0;
    due_d = 1'b0; due_data = '0;
    repeat (2) @(posedge clk);
    #1; init_go = 1'b0; reset = 1'b0;

    step();  // reset state

    // Single fetch
    poke(10'h004, 32'hE1A00001);
    bus.if_req = 1'b1; bus.if_addr = 16'h0004;
    step(); t0 = cur; bus.if_req = 1'b0;
    chk("fetch_gnt", 32'(o_if_gnt), 32'd1);
    step();
    chk("fetch_addr_c1", 32'(o_ram_addr), 32'h0004);
    chk("fetch_busy_c1", 32'(o_busy), 32'd1);
    run_until_rv();
    chk("fetch_latency", 32'(at - t0), 32'(LAT + 2));
    chk("fetch_rdata", o_if_rdata, 32'hE1A00001);

    // Store then load
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h0100; bus.d_wdata = 32'hDEADBEEF;
    step(); t0 = cur; bus.d_req = 1'b0; rw_seen = 0;
    chk("store_gnt", 32'(o_d_gnt), 32'd1);
    run_until_rv();
    chk("store_rw_cycles", 32'(rw_seen), 32'(LAT + 1));
    chk("store_latency", 32'(at - t0), 32'(LAT + 2));
    chk("store_rdata", o_d_rdata, 32'd0);
    bus.d_req = 1'b1; bus.d_we = 1'b0;
    step(); bus.d_req = 1'b0;
    run_until_rv();
    chk("load_rdata", o_d_rdata, 32'hDEADBEEF);

    // Contention: fetch wins after SMAX contended data grants
    bus.if_req = 1'b1; bus.if_addr = 16'h0008; bus.d_req = 1'b1; bus.d_addr = 16'h0020;
    order = '0; n = 0;
    for (int k = 0; k < 70 && n < 10; k++) begin
      step();
      if (o_if_gnt) begin order[n] = 1'b1; n++; end
      else if (o_d_gnt) n++;
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    chk("contend_count", 32'(n), 32'd10);
    chk("contend_order", 32'(order), 32'h210);
    run_until_rv();

    // Reset in the second access cycle drops the load
    bus.d_req = 1'b1; bus.d_addr = 16'h0030;
    step(); bus.d_req = 1'b0;
    step();
    reset = 1'b1; bus.if_req = 1'b1; bus.if_addr = 16'h0040;
    step(); reset = 1'b0;
    chk("rst_no_gnt", 32'(o_if_gnt), 32'd0);
    step(); bus.if_req = 1'b0;
    chk("rst_gnt_after", 32'(o_if_gnt), 32'd1);
    chk("rst_rw_zero", 32'(o_rw), 32'd0);
    chk("rst_addr_zero", 32'(o_ram_addr), 32'd0);
    chk("rst_drdata_zero", o_d_rdata, 32'd0);
    run_until_rv();
    chk("rst_no_d_rvalid", 32'(o_d_rv), 32'd0);
    chk("rst_if_rvalid", 32'(o_if_rv), 32'd1);

    // Data request raised only during RESP then withdrawn
    bus.if_req = 1'b1; bus.if_addr = 16'h000C;
    step(); bus.if_req = 1'b0;
    repeat (LAT + 1) step();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0050;
    step(); bus.d_req = 1'b0;
    chk("withdraw_resp_busy", 32'(o_busy), 32'd1);
    chk("withdraw_resp_gnt", 32'(o_d_gnt), 32'd0);
    step();
    chk("withdraw_idle_gnt", 32'(o_d_gnt), 32'd0);
    chk("withdraw_idle_busy", 32'(o_busy), 32'd0);
    step();
    chk("withdraw_no_access", 32'(o_rw | o_busy), 32'd0);

`ifdef MEMARB_STALL_CNT_EN
    // Fetch waiting behind a data transaction
    bus.if_req = 1'b1; bus.if_addr = 16'h0010; bus.d_req = 1'b1; bus.d_addr = 16'h0014;
    step(); bus.d_req = 1'b0; t0 = cur; s0 = o_stall;
    gcyc = -1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (o_if_gnt) begin gcyc = cur; break; end
    end
    bus.if_req = 1'b0;
    chk("stall_gnt_cycle", 32'(gcyc - t0), 32'(LAT + 3));
    chk("stall_delta", 32'(o_stall - s0), 32'(LAT + 3));
    run_until_rv();
`endif

    // Random traffic with occasional withdrawals and resets
    for (int k = 0; k < 500; k++) begin
      if (bus.if_req) begin
        if ($urandom_range(0, 15) == 0) bus.if_req = 1'b0;
      end else if ($urandom_range(0, 1) == 1) begin
        bus.if_req = 1'b1; bus.if_addr = 16'($urandom_range(0, 31));
      end
      if (bus.d_req) begin
        if ($urandom_range(0, 15) == 0) bus.d_req = 1'b0;
      end else if ($urandom_range(0, 1) == 1) begin
        bus.d_req = 1'b1; bus.d_we = 1'($urandom_range(0, 1));
        bus.d_addr = 16'($urandom_range(0, 31)); bus.d_wdata = $urandom;
      end
      reset = ($urandom_range(0, 63) == 0);
      step();
      if (e_if_gnt) bus.if_req = 1'b0;
      if (e_d_gnt)  bus.d_req  = 1'b0;
    end
    reset = 1'b0; bus.if_req = 1'b0; bus.d_req = 1'b0;
    repeat (LAT + 4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences the single shared RAM port between two requesters: instruction fetch (PC side) and data access (LDR/STR side).
- Replaces the combinational address-bus mux select with a registered request/grant/response controller.
- Drives ram address, read/write and write data. Returns read data to the winning requester.
- One transaction in flight at a time. Data has priority, with an anti-starvation guarantee for fetch.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 32, data width.
- RAM_LAT, 0, RAM read latency in cycles after address is presented. Legal range 0..7.
- STARVE_MAX, 4, number of consecutive contended data grants after which fetch must win. Legal range 1..15.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  ADDR_W  fetch address; stable while if_req is high.
- if_gnt  out  1  fetch accepted this cycle.
- if_rvalid  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  DATA_W  fetched instruction.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data accepted this cycle.
- d_rvalid  out  1  one-cycle completion pulse for loads and stores.
- d_rdata  out  DATA_W  load data; 0 for stores.
- ram_rw  out  1  1 = write, 0 = read.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset: applied at the clk edge while reset=1.
  - State goes to IDLE; starve_cnt=0.
  - All outputs are 0, including ram_addr, ram_wdata, both rdata registers and ram_rw.
  - A transaction in flight is dropped: no rvalid is produced and ram_rw is 0 from the next cycle.
- States:
  - IDLE: grant logic active.
  - ACCESS: RAM_LAT+1 cycles, tracked by a 3-bit down-counter.
  - RESP: 1 cycle.
- Arbitration in IDLE (combinational gnt, at most one gnt high):
  - d_req only -> d_gnt.
  - if_req only -> if_gnt.
  - Both requesting -> d_gnt, unless starve_cnt==STARVE_MAX, in which case if_gnt.
  - Neither requesting -> no gnt.
  - gnt is 0 in ACCESS and RESP.
- Grant edge (end of the gnt cycle):
  - Latch winner address into ram_addr.
  - Set ram_rw=d_we for data, 0 for fetch.
  - Latch ram_wdata=d_wdata for data.
  - Record the source; go to ACCESS with counter=RAM_LAT.
- ACCESS:
  - ram_addr, ram_rw and ram_wdata held stable.
  - The counter decrements each cycle.
  - In the cycle where counter==0, at the clock edge:
    - capture ram_rdata into the source's rdata register (stores capture 0);
    - clear ram_rw;
    - go to RESP.
- RESP: pulse the source's rvalid; next state is IDLE.
- Latency: rvalid is asserted RAM_LAT+2 cycles after the gnt cycle. Throughput is one transaction per RAM_LAT+3 cycles.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) on a data grant while if_req=1.
  - Clears on any fetch grant.
  - Unchanged otherwise.
- Idle outputs: ram_addr and ram_wdata hold their last values. rdata registers hold until overwritten.
- Requests dropped before gnt are legal and ignored; no state change.
- Requests arriving during ACCESS or RESP wait. They are arbitrated in the first IDLE cycle.
- Simultaneous reset and req: reset wins, no gnt registered.

Optional Feature:
- Macro MEMARB_STALL_CNT_EN.
- Defined:
  - Adds output stall_cycles (16 bits).
  - It counts cycles where (if_req & ~if_gnt) | (d_req & ~d_gnt), saturating at 0xFFFF.
  - Cleared by reset.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package memarb_pkg:
  - state enum (IDLE, ACCESS, RESP);
  - source enum (SRC_IF, SRC_D);
  - RAM_RD=0 / RAM_WR=1 constants;
  - default widths.
- One sub-module, memarb_prio:
  - holds starve_cnt;
  - produces the combinational if_gnt/d_gnt decision;
  - inputs are reqs, the idle flag and the reset.

Test Plan:
- Single fetch, RAM_LAT=0: if_req, if_addr=0x0004, RAM returns 0xE1A00001 -> if_gnt in cycle 0, ram_addr=0x0004 in cycle 1, if_rvalid with if_rdata=0xE1A00001 in cycle 2, busy high in cycles 1-2.
- Store then load, RAM_LAT=2: d_we=1, d_addr=0x0100, d_wdata=0xDEADBEEF -> ram_rw=1 for exactly 3 cycles, d_rvalid 4 cycles after gnt, d_rdata=0. A following load of 0x0100 returns 0xDEADBEEF.
- Contention/starvation, STARVE_MAX=4: if_req and d_req held high continuously -> grant order D,D,D,D,IF,D,D,D,D,IF. The if_gnt cycle clears starve_cnt.
- Reset mid-ACCESS, RAM_LAT=3: reset pulsed one cycle in the second ACCESS cycle -> no rvalid, ram_rw=0 and all outputs 0 the next cycle, a new if_req is granted the cycle after reset deasserts.
- Request withdrawn: d_req high for one cycle during RESP, then low -> no d_gnt, no RAM access, busy low after RESP.
- MEMARB_STALL_CNT_EN: fetch blocked behind a data transaction with RAM_LAT=1 -> stall_cycles increments by 4, the fetch being granted in the fifth cycle. Without the macro, the port does not exist.
